// File: rtl/core_out_logger.sv
// Change-triggered logger: samples of core_out are buffered in an 8-deep FIFO
// and sent out as 8N1 UART frames, oldest first.
module core_out_logger #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] core_out,
  output logic       tx,
  output logic       busy,
  output logic [3:0] fifo_count,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

  state_t     r_state;
  logic [7:0] r_prev_q;
  logic [7:0] r_mem [0:7];
  logic [2:0] r_wr_ptr;
  logic [2:0] r_rd_ptr;
  logic [3:0] r_count;
  logic       r_overflow;
  logic [7:0] r_shift;
  logic [2:0] r_bit_idx;
  logic [7:0] r_baud;
  logic       r_tx;

  state_t     w_state_next;
  logic [7:0] w_shift_next;
  logic [2:0] w_bit_idx_next;
  logic [7:0] w_baud_next;
  logic       w_tx_next;

  logic w_capture;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_baud_last;

  assign w_capture   = (core_out != r_prev_q);
  assign w_full      = (r_count == 4'd8);
  assign w_pop       = (r_state == IDLE) && (r_count != 4'd0);
  // A full FIFO still accepts a capture when the head leaves at the same edge.
  assign w_push      = w_capture && (!w_full || w_pop);
  assign w_drop      = w_capture && w_full && !w_pop;
  assign w_baud_last = (r_baud == BAUD_LAST);

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= core_out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_q   <= 8'h00;
      r_wr_ptr   <= 3'd0;
      r_rd_ptr   <= 3'd0;
      r_count    <= 4'd0;
      r_overflow <= 1'b0;
    end else begin
      r_prev_q <= core_out;
      if (w_push) r_wr_ptr <= r_wr_ptr + 3'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 3'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= 8'h00;
      r_bit_idx <= 3'd0;
      r_baud    <= 8'd0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_baud    <= w_baud_next;
      r_tx      <= w_tx_next;
    end
  end

  // tx is computed one edge ahead so the line itself comes straight off a flop.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_baud_next    = r_baud;
    w_tx_next      = r_tx;
    case (r_state)
      IDLE: begin
        w_tx_next = 1'b1;
        if (w_pop) begin
          w_shift_next = r_mem[r_rd_ptr];
          w_state_next = START;
          w_baud_next  = 8'd0;
          w_tx_next    = 1'b0;
        end
      end
      START: begin
        if (w_baud_last) begin
          w_state_next   = DATA;
          w_baud_next    = 8'd0;
          w_bit_idx_next = 3'd0;
          w_tx_next      = r_shift[0];
        end else begin
          w_baud_next = r_baud + 8'd1;
        end
      end
      DATA: begin
        if (w_baud_last) begin
          w_baud_next = 8'd0;
          if (r_bit_idx == 3'd7) begin
            w_state_next = STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_shift_next   = r_shift >> 1;
            w_tx_next      = r_shift[1];
          end
        end else begin
          w_baud_next = r_baud + 8'd1;
        end
      end
      STOP: begin
        w_tx_next = 1'b1;
        if (w_baud_last) begin
          w_state_next = IDLE;
          w_baud_next  = 8'd0;
        end else begin
          w_baud_next = r_baud + 8'd1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  assign tx         = r_tx;
  assign busy       = (r_state != IDLE);
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_core_out_logger.sv
// Directed bench for core_out_logger at CLKS_PER_BIT=4: reset, single frame,
// hold-off, overflow, mid-frame reset and full-FIFO push-with-pop.
module tb_core_out_logger;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] core_out;
  logic       tx;
  logic       busy;
  logic [3:0] fifo_count;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  core_out_logger #(.CLKS_PER_BIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_out   (core_out),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called while observing the cycle at frame index start_i (0 = first start-bit
  // cycle), or with start_i < 0 to wait for the falling edge first.
  task automatic recv_frame(input logic [7:0] exp, input int start_i, input logic [7:0] pre);
    logic [7:0] data;
    int         i;
    logic       found;
    data = pre;
    i    = start_i;
    if (start_i < 0) begin
      found = 1'b0;
      for (int n = 0; n < 200; n++) begin
        if (tx === 1'b0) begin
          found = 1'b1;
          break;
        end
        tick();
      end
      check("frame_start_seen", {7'b0, found}, 8'h01);
      if (found !== 1'b1) return;
      i = 0;
    end
    while (i < 40) begin
      if (i == 2) check("start_bit", {7'b0, tx}, 8'h00);
      if (i >= 4 && i < 36 && (i % 4) == 2) data[(i - 4) / 4] = tx;
      if (i == 38) check("stop_bit", {7'b0, tx}, 8'h01);
      tick();
      i++;
    end
    check($sformatf("frame_%h", exp), data, exp);
  endtask

  initial begin
    logic [7:0] a5;
    logic       exp_tx;
    logic       b0;

    a5       = 8'hA5;
    b0       = 1'b0;
    reset    = 1'b1;
    core_out = 8'h00;

    // Reset held for 5 cycles.
    for (int c = 0; c < 5; c++) begin
      tick();
      check("rst_tx",    {7'b0, tx},       8'h01);
      check("rst_busy",  {7'b0, busy},     8'h00);
      check("rst_count", {4'b0, fifo_count}, 8'h00);
      check("rst_ovf",   {7'b0, overflow}, 8'h00);
    end
    reset = 1'b0;

    // Held 00 after release: nothing captured.
    for (int c = 0; c < 3; c++) begin
      tick();
      check("hold00_busy",  {7'b0, busy},       8'h00);
      check("hold00_count", {4'b0, fifo_count}, 8'h00);
    end

    // Single A5 frame, checked cycle by cycle.
    core_out = 8'hA5;
    tick();
    check("a5_capture_count", {4'b0, fifo_count}, 8'h01);
    check("a5_capture_tx",    {7'b0, tx},         8'h01);
    check("a5_capture_busy",  {7'b0, busy},       8'h00);
    tick();
    for (int i = 0; i < 40; i++) begin
      if (i < 4)       exp_tx = 1'b0;
      else if (i < 36) exp_tx = a5[(i - 4) / 4];
      else             exp_tx = 1'b1;
      check($sformatf("a5_tx_%0d", i),   {7'b0, tx},   {7'b0, exp_tx});
      check($sformatf("a5_busy_%0d", i), {7'b0, busy}, 8'h01);
      tick();
    end
    check("a5_end_busy",  {7'b0, busy},       8'h00);
    check("a5_end_count", {4'b0, fifo_count}, 8'h00);
    check("a5_end_tx",    {7'b0, tx},         8'h01);

    // Change to 3C: one frame, then a long hold produces nothing more.
    core_out = 8'h3C;
    tick();
    recv_frame(8'h3C, -1, 8'h00);
    for (int c = 0; c < 100; c++) begin
      tick();
      check("hold3c_busy",  {7'b0, busy},       8'h00);
      check("hold3c_count", {4'b0, fifo_count}, 8'h00);
    end

    // 01..0A on consecutive edges: 01 goes straight out, 02..09 fill the FIFO, 0A is dropped.
    for (int j = 1; j <= 10; j++) begin
      core_out = 8'(j);
      tick();
      if (j == 8) b0 = tx;
      if (j == 9) begin
        check("ovf_fill_count", {4'b0, fifo_count}, 8'h08);
        check("ovf_fill_flag",  {7'b0, overflow},   8'h00);
      end
      if (j == 10) begin
        check("ovf_drop_count", {4'b0, fifo_count}, 8'h08);
        check("ovf_drop_flag",  {7'b0, overflow},   8'h01);
      end
    end
    recv_frame(8'h01, 8, {7'b0, b0});
    for (int j = 2; j <= 9; j++) recv_frame(8'(j), -1, 8'h00);
    for (int c = 0; c < 50; c++) tick();
    check("ovf_after_busy",  {7'b0, busy},       8'h00);
    check("ovf_after_count", {4'b0, fifo_count}, 8'h00);
    check("ovf_sticky",      {7'b0, overflow},   8'h01);

    // Reset during DATA of frame 01 with 02..04 queued.
    for (int j = 1; j <= 4; j++) begin
      core_out = 8'(j);
      tick();
    end
    for (int c = 0; c < 6; c++) tick();
    check("mid_busy",  {7'b0, busy},       8'h01);
    check("mid_count", {4'b0, fifo_count}, 8'h03);
    check("mid_tx",    {7'b0, tx},         8'h00);
    #2;
    reset    = 1'b1;
    core_out = 8'h00;
    #1;
    check("async_rst_tx",    {7'b0, tx},         8'h01);
    check("async_rst_busy",  {7'b0, busy},       8'h00);
    check("async_rst_count", {4'b0, fifo_count}, 8'h00);
    check("async_rst_ovf",   {7'b0, overflow},   8'h00);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      check("post_rst_busy",  {7'b0, busy},       8'h00);
      check("post_rst_tx",    {7'b0, tx},         8'h01);
      check("post_rst_count", {4'b0, fifo_count}, 8'h00);
    end
    core_out = 8'h5A;
    tick();
    recv_frame(8'h5A, -1, 8'h00);
    check("post_rst_ovf", {7'b0, overflow}, 8'h00);

    // Full FIFO with a capture on the very edge the FSM pops.
    for (int j = 1; j <= 9; j++) begin
      core_out = 8'h20 + 8'(j);
      tick();
    end
    check("full_count", {4'b0, fifo_count}, 8'h08);
    check("full_ovf",   {7'b0, overflow},   8'h00);
    for (int c = 0; c < 33; c++) tick();
    check("full_idle_busy",  {7'b0, busy},       8'h00);
    check("full_idle_count", {4'b0, fifo_count}, 8'h08);
    core_out = 8'h2A;
    tick();
    check("pushpop_count", {4'b0, fifo_count}, 8'h08);
    check("pushpop_ovf",   {7'b0, overflow},   8'h00);
    check("pushpop_busy",  {7'b0, busy},       8'h01);
    for (int j = 2; j <= 10; j++) recv_frame(8'h20 + 8'(j), -1, 8'h00);
    tick();
    check("final_count", {4'b0, fifo_count}, 8'h00);
    check("final_ovf",   {7'b0, overflow},   8'h00);
    check("final_busy",  {7'b0, busy},       8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_out_logger.md
CORE_OUT_LOGGER -- requirements
Module: core_out_logger

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per UART bit; legal range 2..255.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port core_out, input, 8, the core's 8-bit output value, synchronous to clk.
REQ-005 SHALL have port tx, output, 1, UART serial line, 8N1, idle high.
REQ-006 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-007 SHALL have port fifo_count, output, 4, number of buffered samples (0..8).
REQ-008 SHALL have port overflow, output, 1, sticky flag: a sample was dropped.

Function
REQ-009 SHALL keep prev_q, an 8-bit register loaded with core_out on every rising edge.
REQ-010 SHALL raise a capture at edge k when core_out != prev_q; otherwise no capture.
REQ-011 SHALL keep an 8-entry FIFO of 8-bit samples; a capture writes core_out into it at the same edge.
REQ-012 SHALL use 3-bit read/write pointers that wrap 7->0, and a 4-bit count.
REQ-013 SHALL, when a capture occurs with count==8 and no pop at that edge, drop the sample, leave FIFO and count unchanged, and set overflow=1.
REQ-014 SHALL, when a capture and a pop occur at the same edge with count==8, accept the push; count stays 8.
REQ-015 SHALL, on a simultaneous push and pop at any count, leave count unchanged.
REQ-016 SHALL hold overflow at 1 until reset.
REQ-017 SHALL implement the TX FSM states IDLE, START, DATA, STOP.
REQ-018 SHALL, in IDLE with count>0 at an edge, pop the head into an 8-bit shift register and enter START.
REQ-019 SHALL, in IDLE with count==0, stay in IDLE.
REQ-020 SHALL drive tx=0 in START for CLKS_PER_BIT cycles, then enter DATA.
REQ-021 SHALL, in DATA, drive 8 bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit bit index and a baud counter, then enter STOP.
REQ-022 SHALL drive tx=1 in STOP for CLKS_PER_BIT cycles, then enter IDLE.
REQ-023 SHALL give each frame 10*CLKS_PER_BIT cycles, with at least one IDLE cycle between back-to-back frames.
REQ-024 SHALL drive busy=1 exactly when the state != IDLE.
REQ-025 SHALL drive tx=1 in IDLE.
REQ-026 SHALL drive tx directly from a register (glitch-free).
REQ-027 SHALL give latency: a capture at edge k with an empty FIFO and the FSM in IDLE gives a pop at edge k+1, with tx falling after edge k+1.
REQ-028 SHALL transmit samples in capture order; no sample is duplicated.

Reset
REQ-029 SHALL, while reset=1 and regardless of clk, force: tx=1, busy=0, fifo_count=0, overflow=0, state=IDLE, pointers=0, prev_q=8'h00, baud counter=0, bit index=0.
REQ-030 SHALL, on reset asserted mid-frame, abort the frame immediately (tx=1) and discard all buffered samples; no partial frame resumes after release.
REQ-031 SHALL, after reset release, capture only when core_out != 8'h00; a held value of 00 produces no frame.

Verification
REQ-032 SHALL cover: assert reset for 5 cycles -> tx=1, busy=0, fifo_count=0, overflow=0 throughout.
REQ-033 SHALL cover: after reset, core_out 00->A5 and held (CLKS_PER_BIT=4) -> one frame: 4 cycles low, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 4 cycles high; busy high for 40 cycles; fifo_count back to 0.
REQ-034 SHALL cover: core_out held at 3C for 100 cycles after one frame -> no further frame, fifo_count=0.
REQ-035 SHALL cover: core_out = 01,02,...,0A on 10 consecutive cycles from an empty FIFO -> fifo_count peaks at 8, 0A is dropped, overflow=1; frames 01..09 are emitted in order; overflow stays 1 afterwards.
REQ-036 SHALL cover: reset pulsed during the DATA state of frame 01 with 3 samples queued -> tx=1 within the same cycle, fifo_count=0, no frames after release until core_out changes.
REQ-037 SHALL cover: FIFO full, a new capture at the same edge the FSM pops -> push accepted, fifo_count stays 8, overflow unchanged.
